// File: rtl/fivesons_pkg.sv
// Shared FiveSons board definitions: geometry, cell encodings, reader states
// and the (x,y) -> bit-offset mapping used by both board writer and reader.
package fivesons_pkg;

  localparam int GRID    = 16;
  localparam int CELL_W  = 2;
  localparam int BOARD_W = GRID * GRID * CELL_W;
  localparam int COORD_W = $clog2(GRID);
  localparam int CNT_W   = $clog2(GRID * GRID + 1);
  localparam int OFF_W   = $clog2(BOARD_W);

  localparam logic [CELL_W-1:0] CELL_EMPTY = 2'b00;
  localparam logic [CELL_W-1:0] CELL_BLACK = 2'b01;
  localparam logic [CELL_W-1:0] CELL_WHITE = 2'b10;
  localparam logic [CELL_W-1:0] CELL_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } reader_state_e;

  // Bit offset of cell (x,y) in the packed board: rows of GRID cells, x fastest.
  function automatic logic [OFF_W-1:0] co_to_offset(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y);
    return OFF_W'((int'(y) * GRID + int'(x)) * CELL_W);
  endfunction

endpackage

// File: rtl/board_cell_reader.sv
// Snapshots the packed board on start and streams every cell in raster order
// over a valid/ready handshake, tallying black and white stones as beats go out.
module board_cell_reader
  import fivesons_pkg::*;
(
  input  logic               Clck,
  input  logic               Reset,
  input  logic               start,
  input  logic [BOARD_W-1:0] board,
  output logic               busy,
  output logic               cell_valid,
  input  logic               cell_ready,
  output logic [COORD_W-1:0] cell_x,
  output logic [COORD_W-1:0] cell_y,
  output logic [CELL_W-1:0]  cell_state,
  output logic               done,
  output logic [CNT_W-1:0]   count_black,
  output logic [CNT_W-1:0]   count_white
);

  reader_state_e      state_q, state_d;
  logic [BOARD_W-1:0] shadow_q, shadow_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               valid_q, valid_d;
  logic [CELL_W-1:0]  cell_q, cell_d;
  logic [CNT_W-1:0]   black_q, black_d, white_q, white_d;

  logic               xfer;
  logic               x_last;
  logic               last_beat;
  logic [COORD_W-1:0] x_nxt, y_nxt;
  logic [OFF_W-1:0]   off_nxt;

  assign xfer      = valid_q & cell_ready;
  assign x_last    = (x_q == COORD_W'(GRID - 1));
  assign last_beat = x_last & (y_q == COORD_W'(GRID - 1));
  assign x_nxt     = x_last ? '0 : x_q + 1'b1;
  assign y_nxt     = x_last ? y_q + 1'b1 : y_q;
  assign off_nxt   = co_to_offset(x_nxt, y_nxt);

  // State and datapath registers; reset aborts any scan without a done pulse.
  always_ff @(posedge Clck) begin
    if (Reset) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
      cell_q   <= '0;
      black_q  <= '0;
      white_q  <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      x_q      <= x_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      cell_q   <= cell_d;
      black_q  <= black_d;
      white_q  <= white_d;
    end
  end

  // Next-state logic: capture on start, advance and tally on each transfer.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    x_d      = x_q;
    y_d      = y_q;
    valid_d  = valid_q;
    cell_d   = cell_q;
    black_d  = black_q;
    white_d  = white_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SCAN;
          shadow_d = board;
          x_d      = '0;
          y_d      = '0;
          black_d  = '0;
          white_d  = '0;
          valid_d  = 1'b1;
          // Shadow is loaded on this same edge, so the first cell comes from board.
          cell_d   = board[co_to_offset('0, '0) +: CELL_W];
        end
      end
      SCAN: begin
        if (xfer) begin
          if (cell_q == CELL_BLACK) black_d = black_q + 1'b1;
          if (cell_q == CELL_WHITE) white_d = white_q + 1'b1;
          if (last_beat) begin
            valid_d = 1'b0;
            state_d = DONE;
          end else begin
            x_d    = x_nxt;
            y_d    = y_nxt;
            cell_d = shadow_q[off_nxt +: CELL_W];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign cell_valid  = valid_q;
  assign cell_x      = x_q;
  assign cell_y      = y_q;
  assign cell_state  = cell_q;
  assign count_black = black_q;
  assign count_white = white_q;

endmodule

// File: tb/tb_board_cell_reader.sv
// Scoreboard bench for board_cell_reader: stimulus pushes the expected beat
// stream and stone counts; a monitor pops and compares on every transfer/done.
module tb_board_cell_reader;
  import fivesons_pkg::*;

  logic               Clck = 1'b0;
  logic               Reset;
  logic               start;
  logic [BOARD_W-1:0] board;
  logic               busy;
  logic               cell_valid;
  logic               cell_ready;
  logic [COORD_W-1:0] cell_x;
  logic [COORD_W-1:0] cell_y;
  logic [CELL_W-1:0]  cell_state;
  logic               done;
  logic [CNT_W-1:0]   count_black;
  logic [CNT_W-1:0]   count_white;

  board_cell_reader dut (
    .Clck(Clck), .Reset(Reset), .start(start), .board(board), .busy(busy),
    .cell_valid(cell_valid), .cell_ready(cell_ready), .cell_x(cell_x),
    .cell_y(cell_y), .cell_state(cell_state), .done(done),
    .count_black(count_black), .count_white(count_white)
  );

  always #5 Clck = ~Clck;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [CELL_W-1:0]  st;
  } beat_t;

  beat_t exp_q[$];
  int    expb_q[$];
  int    expw_q[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int beat_n = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // Reference model: walk the board row by row, x fastest, straight from the
  // documented bit layout, and count stones of each colour.
  task automatic push_scan(input logic [BOARD_W-1:0] b);
    int nb = 0;
    int nw = 0;
    beat_t e;
    for (int y = 0; y < GRID; y++) begin
      for (int x = 0; x < GRID; x++) begin
        e.x  = COORD_W'(x);
        e.y  = COORD_W'(y);
        e.st = b[(y * GRID + x) * CELL_W +: CELL_W];
        if (e.st == 2'b01) nb++;
        if (e.st == 2'b10) nw++;
        exp_q.push_back(e);
      end
    end
    expb_q.push_back(nb);
    expw_q.push_back(nw);
  endtask

  initial forever begin
    @(posedge Clck);
    cyc <= cyc + 1;
  end

  initial begin
    cell_ready = 1'b1;
    forever begin
      @(posedge Clck);
      #1;
      cell_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: checks transfers, stall stability, and done timing/counts.
  initial begin
    bit    prev_stall = 1'b0;
    bit    prev_done  = 1'b0;
    logic [COORD_W*2+CELL_W:0] saved = '0;
    beat_t e;
    forever begin
      @(negedge Clck);
      if (Reset) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (prev_stall)
          chk("stall_hold", {cell_valid, cell_x, cell_y, cell_state}, saved);
        if (cell_valid && cell_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_beat: got x=%0d y=%0d st=%0d expected none", cell_x, cell_y, cell_state);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {cell_x, cell_y, cell_state}, e);
            if (beat_n == 0) first_cyc = cyc;
            last_cyc = cyc;
            beat_n++;
          end
        end
        prev_stall = cell_valid && !cell_ready;
        saved      = {cell_valid, cell_x, cell_y, cell_state};
        if (done) begin
          chk("done_width", prev_done, 0);
          chk("done_latency", cyc, last_cyc + 1);
          chk("done_all_beats", exp_q.size(), 0);
          chk("done_busy", busy, 1);
          if (expb_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done: got done=1 expected no done");
          end else begin
            chk("count_black", count_black, expb_q.pop_front());
            chk("count_white", count_white, expw_q.pop_front());
          end
        end
        prev_done = done;
      end
    end
  end

  task automatic start_scan(input logic [BOARD_W-1:0] b);
    board  = b;
    beat_n = 0;
    push_scan(b);
    start = 1'b1;
    @(posedge Clck);
    #1 start = 1'b0;
    @(negedge Clck);
    chk("first_valid", cell_valid, 1);
    chk("first_busy", busy, 1);
  endtask

  task automatic wait_beat(input int n);
    int t = 0;
    while (beat_n < n && t < 4000) begin
      @(negedge Clck);
      t++;
    end
    chk("beat_timeout", t < 4000, 1);
    @(posedge Clck);
    #1;
  endtask

  // Waits for done; optionally pokes start during the DONE cycle.
  task automatic wait_done(input bit poke);
    int t = 0;
    while (!done && t < 4000) begin
      @(negedge Clck);
      t++;
    end
    chk("done_timeout", t < 4000, 1);
    if (poke) start = 1'b1;
    @(posedge Clck);
    #1 start = 1'b0;
    chk("idle_busy", busy, 0);
    @(negedge Clck);
    chk("idle_no_valid", cell_valid, 0);
    if (!rand_ready) chk("b2b_span", last_cyc - first_cyc, GRID * GRID - 1);
    @(posedge Clck);
    #1;
  endtask

  function automatic logic [BOARD_W-1:0] rand_board();
    logic [BOARD_W-1:0] b;
    for (int i = 0; i < BOARD_W / 32; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  initial begin
    logic [BOARD_W-1:0] b;
    Reset = 1'b1;
    start = 1'b0;
    board = rand_board();
    repeat (2) @(posedge Clck);
    @(negedge Clck);
    chk("rst_outputs", {busy, cell_valid, done, cell_x, cell_y, cell_state}, 0);
    chk("rst_counts", {count_black, count_white}, 0);
    @(posedge Clck);
    #1 Reset = 1'b0;

    // Empty board, ready always high
    start_scan('0);
    wait_done(1'b0);

    // Black at (3,7), white at (15,15)
    b = '0;
    b[(7 * GRID + 3) * CELL_W +: CELL_W]   = 2'b01;
    b[(15 * GRID + 15) * CELL_W +: CELL_W] = 2'b10;
    start_scan(b);
    wait_done(1'b0);

    // Random boards with random back-pressure
    rand_ready = 1'b1;
    repeat (3) begin
      start_scan(rand_board());
      wait_done(1'b0);
    end
    start_scan(b);
    wait_done(1'b0);

    // Board change mid-scan and ignored starts during SCAN and DONE
    start_scan(rand_board());
    wait_beat(10);
    board = {(GRID * GRID){2'b01}};
    start = 1'b1;
    @(posedge Clck);
    #1 start = 1'b0;
    wait_done(1'b1);
    repeat (3) @(posedge Clck);
    #1;
    chk("no_rescan", {busy, cell_valid}, 0);

    // Reset in the middle of a scan
    start_scan(rand_board());
    wait_beat(100);
    Reset = 1'b1;
    exp_q.delete();
    expb_q.delete();
    expw_q.delete();
    @(posedge Clck);
    @(negedge Clck);
    chk("abort_outputs", {busy, cell_valid, done, cell_x, cell_y, cell_state}, 0);
    chk("abort_counts", {count_black, count_white}, 0);
    @(posedge Clck);
    #1 Reset = 1'b0;
    repeat (4) @(negedge Clck);
    chk("abort_no_done", {done, busy, cell_valid}, 0);
    @(posedge Clck);
    #1;
    start_scan(rand_board());
    wait_done(1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
